cgra_context_sequencer: RTL and testbench
=========================================

Name: cgra_context_sequencer

Overview:
- Per-column controller for a group of reconfigurable cells (RCs).
- Two jobs: sequences the configuration load into the RCs' configuration register files, then drives execution.
- During execution it drives the shared global PC, pc_en, conf_we and conf_re. It also resolves branch requests, stall requests and end-of-kernel from the RCs.
- Sits between the CGRA top-level control/config DMA and the RC array.

Parameters:
- N_RC, 4, number of RCs controlled; all per-RC vectors are N_RC wide.
- NUM_CREG, 32, configuration registers per RC; PCW = $clog2(NUM_CREG).
- INSTR_W, 32, configuration word width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- load_i  in  1  pulse: start a configuration load (IDLE only)
- load_len_i  in  PCW+1  number of configuration addresses to load (1..NUM_CREG)
- start_i  in  1  pulse: start execution (IDLE only)
- start_pc_i  in  PCW  first instruction address
- cfg_valid_i  in  1  configuration word valid
- cfg_data_i  in  INSTR_W  configuration word
- cfg_ready_o  out  1  configuration word accepted when valid&ready
- conf_wdata_o  out  INSTR_W  word broadcast to all RCs
- conf_we_o  out  N_RC  one-hot write enable
- conf_re_o  out  1  read enable to all RCs
- global_pc_o  out  PCW  shared PC for load address and execution
- pc_en_o  out  1  PC / datapath clock-enable to all RCs
- rc_stall_i  in  N_RC  per-RC stall
- br_req_i  in  N_RC  per-RC branch request
- br_add_i  in  N_RC*PCW  per-RC branch target; slice i = RC i
- exec_end_i  in  N_RC  per-RC end of kernel
- busy_o  out  1  not IDLE
- done_o  out  1  one-cycle pulse at kernel end

Behaviour:
- States: IDLE, LOAD, EXEC, DONE.
- Reset values: state IDLE; all outputs 0; internal counters 0.
  - rst_i mid-LOAD or mid-EXEC aborts immediately; no partial done_o.
- IDLE:
  - load_i → LOAD: addr=0, rc_idx=0, cnt=load_len_i.
  - else start_i → EXEC: pc=start_pc_i.
  - load_i and start_i in the same cycle: load wins and start is dropped.
  - load_len_i=0 is treated as NUM_CREG.
- LOAD:
  - cfg_ready_o=1.
  - On each cfg_valid_i&cfg_ready_o handshake, in the same cycle (combinational from valid):
    - conf_we_o = one-hot(rc_idx)
    - conf_wdata_o = cfg_data_i
    - global_pc_o = addr
  - Word order: address-major, RC-minor (addr0:RC0..RC(N-1), addr1:RC0..).
  - After each handshake rc_idx increments. At N_RC-1 it wraps to 0 and addr increments.
  - After the handshake with addr = cnt-1 and rc_idx = N_RC-1 → IDLE, with one done_o pulse.
  - No valid → hold; conf_we_o=0.
  - conf_re_o=0 and pc_en_o=0 throughout LOAD.
- EXEC:
  - conf_re_o=1; global_pc_o=pc.
  - pc_en_o = ~|rc_stall_i (combinational).
  - When pc_en_o=1, the next pc is chosen by priority:
    1. |exec_end_i → DONE, pc unchanged.
    2. |br_req_i → pc = br_add_i of the lowest-index requesting RC.
    3. otherwise pc+1; NUM_CREG-1 wraps to 0.
  - When pc_en_o=0 (stall): pc, state and pending branch/end are all held. Branch and end are evaluated only in a cycle with pc_en_o=1.
  - load_i and start_i are ignored while busy.
- DONE:
  - One cycle; done_o=1; conf_re_o=0; pc_en_o=0 → IDLE.
- busy_o = (state != IDLE).

Optional Feature:
- Macro CGRA_SEQ_PERF_CNT_EN.
- When defined: extra outputs exec_cycles_o[31:0] and stall_cycles_o[31:0].
  - Both clear on entry to EXEC.
  - exec_cycles_o increments every EXEC cycle.
  - stall_cycles_o increments every EXEC cycle with pc_en_o=0.
  - Both saturate at 2^32-1 and hold after DONE until the next start.
- When undefined: the ports still exist, tied to 0, and no counter flops are inferred.

Test Plan:
- Load, N_RC=4, load_len_i=2: 8 words D0..D7 with valid always high → conf_we_o 0001,0010,0100,1000,0001..1000; global_pc_o 0,0,0,0,1,1,1,1; done_o on the 8th handshake; busy_o then 0.
- Load with backpressure: cfg_valid_i toggles every other cycle → exactly 8 writes, no conf_we_o while valid=0, same address/RC order.
- Execution with branch: start_pc_i=3, no stalls, br_req_i=0110 at pc=5 with br_add[1]=9, br_add[2]=12 → PC sequence 3,4,5,9,...
- Stall hold: at pc=7, rc_stall_i=0100 for 3 cycles together with br_req_i=0001 → pc_en_o=0 and global_pc_o=7 for 3 cycles; branch taken on the first unstalled cycle.
- End with simultaneous branch: exec_end_i=1000 and br_req_i=0001 at pc=10 → DONE, done_o one pulse, no branch; with the macro, exec_cycles_o equals the cycle count since start.
- Reset and collisions: rst_i mid-EXEC → all outputs 0 next cycle, no done_o. In IDLE, load_i and start_i together → LOAD entered, start dropped. PC wraps 31→0 when NUM_CREG=32.

Source files
------------

// File: rtl/cgra_context_sequencer.sv
// cgra_context_sequencer: per-column CGRA controller.
// It streams configuration words into the RC register files, then runs the kernel.
// During a run it drives the shared PC and resolves stall, branch and end requests from the RCs.
// Optional build macro CGRA_SEQ_PERF_CNT_EN adds execution and stall cycle counters.
// Without the macro, those counter ports are tied to zero.
module cgra_context_sequencer #(
  parameter int N_RC     = 4,
  parameter int NUM_CREG = 32,
  parameter int INSTR_W  = 32,
  localparam int PCW     = $clog2(NUM_CREG),
  localparam int RCW     = (N_RC > 1) ? $clog2(N_RC) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic [PCW:0]        load_len_i,
  input  logic                start_i,
  input  logic [PCW-1:0]      start_pc_i,
  input  logic                cfg_valid_i,
  input  logic [INSTR_W-1:0]  cfg_data_i,
  output logic                cfg_ready_o,
  output logic [INSTR_W-1:0]  conf_wdata_o,
  output logic [N_RC-1:0]     conf_we_o,
  output logic                conf_re_o,
  output logic [PCW-1:0]      global_pc_o,
  output logic                pc_en_o,
  input  logic [N_RC-1:0]     rc_stall_i,
  input  logic [N_RC-1:0]     br_req_i,
  input  logic [N_RC*PCW-1:0] br_add_i,
  input  logic [N_RC-1:0]     exec_end_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [31:0]         exec_cycles_o,
  output logic [31:0]         stall_cycles_o
);

  typedef enum logic [1:0] {IDLE, LOAD, EXEC, DONE} state_t;

  state_t         state, state_n;
  logic [PCW-1:0] addr, addr_n;
  logic [RCW-1:0] rc_idx, rc_n;
  logic [PCW:0]   cnt, cnt_n;
  logic [PCW-1:0] pc, pc_n;
  logic           br_hit;
  logic [PCW-1:0] br_tgt;
  logic           load_last;
  logic           exec_entry;

  assign load_last  = ({1'b0, addr} == (cnt - (PCW+1)'(1))) && (rc_idx == RCW'(N_RC - 1));
  assign exec_entry = (state == IDLE) && !load_i && start_i;
  assign busy_o     = (state != IDLE);

  // Branch target of the lowest-index requesting RC (the last assignment in the loop wins).
  always_comb begin
    br_hit = 1'b0;
    br_tgt = '0;
    for (int i = N_RC - 1; i >= 0; i--) begin
      if (br_req_i[i]) begin
        br_hit = 1'b1;
        br_tgt = br_add_i[i*PCW +: PCW];
      end
    end
  end

  // Sequencer state and counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      addr   <= '0;
      rc_idx <= '0;
      cnt    <= '0;
      pc     <= '0;
    end else begin
      state  <= state_n;
      addr   <= addr_n;
      rc_idx <= rc_n;
      cnt    <= cnt_n;
      pc     <= pc_n;
    end
  end

  // Next-state logic and outputs. Load strobes follow cfg_valid_i combinationally.
  always_comb begin
    state_n      = state;
    addr_n       = addr;
    rc_n         = rc_idx;
    cnt_n        = cnt;
    pc_n         = pc;
    cfg_ready_o  = 1'b0;
    conf_wdata_o = '0;
    conf_we_o    = '0;
    conf_re_o    = 1'b0;
    global_pc_o  = '0;
    pc_en_o      = 1'b0;
    done_o       = 1'b0;
    case (state)
      IDLE: begin
        if (load_i) begin
          state_n = LOAD;
          addr_n  = '0;
          rc_n    = '0;
          // A length of zero means a full register file.
          cnt_n   = (load_len_i == '0) ? (PCW+1)'(NUM_CREG) : load_len_i;
        end else if (start_i) begin
          state_n = EXEC;
          pc_n    = start_pc_i;
        end
      end
      LOAD: begin
        cfg_ready_o = 1'b1;
        global_pc_o = addr;
        if (cfg_valid_i) begin
          conf_we_o    = N_RC'(1) << rc_idx;
          conf_wdata_o = cfg_data_i;
          if (load_last) begin
            state_n = IDLE;
            done_o  = 1'b1;
          end else if (rc_idx == RCW'(N_RC - 1)) begin
            rc_n   = '0;
            addr_n = addr + PCW'(1);
          end else begin
            rc_n = rc_idx + RCW'(1);
          end
        end
      end
      EXEC: begin
        conf_re_o   = 1'b1;
        global_pc_o = pc;
        pc_en_o     = ~|rc_stall_i;
        // A stalled cycle freezes everything; end and branch are decided only on enabled cycles.
        if (pc_en_o) begin
          if (|exec_end_i) begin
            state_n = DONE;
          end else if (br_hit) begin
            pc_n = br_tgt;
          end else begin
            pc_n = (pc == PCW'(NUM_CREG - 1)) ? '0 : pc + PCW'(1);
          end
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef CGRA_SEQ_PERF_CNT_EN
  logic [31:0] exec_cnt, stall_cnt;

  // Saturating run and stall cycle counters. They clear when a run starts and hold after it ends.
  always_ff @(posedge clk_i) begin
    if (rst_i || exec_entry) begin
      exec_cnt  <= '0;
      stall_cnt <= '0;
    end else if (state == EXEC) begin
      if (exec_cnt != '1) exec_cnt <= exec_cnt + 32'd1;
      if (!pc_en_o && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign exec_cycles_o  = exec_cnt;
  assign stall_cycles_o = stall_cnt;
`else
  logic unused_entry;
  assign unused_entry   = exec_entry;
  assign exec_cycles_o  = '0;
  assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_cgra_context_sequencer.sv
// Directed testbench for cgra_context_sequencer (N_RC=4, NUM_CREG=32, INSTR_W=32).
module tb_cgra_context_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [5:0]  load_len;
  logic        start;
  logic [4:0]  start_pc;
  logic        cfg_valid;
  logic [31:0] cfg_data;
  logic        cfg_ready;
  logic [31:0] conf_wdata;
  logic [3:0]  conf_we;
  logic        conf_re;
  logic [4:0]  gpc;
  logic        pc_en;
  logic [3:0]  rc_stall;
  logic [3:0]  br_req;
  logic [19:0] br_add;
  logic [3:0]  exec_end;
  logic        busy;
  logic        done;
  logic [31:0] exec_cyc;
  logic [31:0] stall_cyc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cgra_context_sequencer #(.N_RC(4), .NUM_CREG(32), .INSTR_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .load_i(load), .load_len_i(load_len),
    .start_i(start), .start_pc_i(start_pc), .cfg_valid_i(cfg_valid),
    .cfg_data_i(cfg_data), .cfg_ready_o(cfg_ready), .conf_wdata_o(conf_wdata),
    .conf_we_o(conf_we), .conf_re_o(conf_re), .global_pc_o(gpc), .pc_en_o(pc_en),
    .rc_stall_i(rc_stall), .br_req_i(br_req), .br_add_i(br_add),
    .exec_end_i(exec_end), .busy_o(busy), .done_o(done),
    .exec_cycles_o(exec_cyc), .stall_cycles_o(stall_cyc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exec_chk(input string tag, input logic [4:0] pc_exp, input logic en_exp);
    chk({tag, "_pc"}, 32'(gpc), 32'(pc_exp));
    chk({tag, "_en"}, 32'(pc_en), 32'(en_exp));
    chk({tag, "_re"}, 32'(conf_re), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // Called at a negedge with the DUT already in LOAD; feeds 'words' words.
  task automatic run_load(input string tag, input int words, input bit gaps);
    int k = 0;
    int writes = 0;
    for (int c = 0; c < 2 * words + 4 && k < words; c++) begin
      cfg_valid = gaps ? (c % 2 == 0) : 1'b1;
      cfg_data  = 32'hD000_0000 + 32'(k);
      #1;
      if (conf_we != 4'd0) writes++;
      if (cfg_valid) begin
        chk({tag, "_we"}, 32'(conf_we), 32'(1 << (k % 4)));
        chk({tag, "_addr"}, 32'(gpc), 32'(k / 4));
        chk({tag, "_wdata"}, conf_wdata, 32'hD000_0000 + 32'(k));
        chk({tag, "_done"}, 32'(done), 32'(k == words - 1));
        k++;
      end else begin
        chk({tag, "_we_gap"}, 32'(conf_we), 32'd0);
        chk({tag, "_rdy_gap"}, 32'(cfg_ready), 32'd1);
      end
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    #1;
    chk({tag, "_writes"}, 32'(writes), 32'(words));
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_done_end"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; load_len = '0; start = 1'b0; start_pc = '0;
    cfg_valid = 1'b0; cfg_data = '0; rc_stall = '0; br_req = '0; br_add = '0;
    exec_end = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rdy", 32'(cfg_ready), 32'd0);
    chk("rst_pc", 32'(gpc), 32'd0);
    chk("rst_we", 32'(conf_we), 32'd0);
    chk("rst_re", 32'(conf_re), 32'd0);
    chk("rst_en", 32'(pc_en), 32'd0);
    chk("rst_exec", exec_cyc, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Load of 2 addresses with valid held high.
    @(negedge clk);
    load = 1'b1; load_len = 6'd2;
    @(negedge clk);
    load = 1'b0;
    #1;
    chk("ld_busy", 32'(busy), 32'd1);
    chk("ld_re", 32'(conf_re), 32'd0);
    run_load("ld", 8, 1'b0);

    // Same load with valid toggling every other cycle.
    @(negedge clk);
    load = 1'b1; load_len = 6'd2;
    @(negedge clk);
    load = 1'b0;
    run_load("bp", 8, 1'b1);

    // Execution with a branch, a stall and an end.
    @(negedge clk);
    start = 1'b1; start_pc = 5'd3;
    @(negedge clk);
    start = 1'b0;
    #1 exec_chk("x3", 5'd3, 1'b1);
    chk("x_busy", 32'(busy), 32'd1);
    @(negedge clk);
    #1 exec_chk("x4", 5'd4, 1'b1);
    @(negedge clk);
    br_req = 4'b0110; br_add = {5'd0, 5'd12, 5'd9, 5'd0};
    #1 exec_chk("x5", 5'd5, 1'b1);
    @(negedge clk);
    br_req = 4'b0001; br_add = {15'd0, 5'd7};
    #1 exec_chk("x9", 5'd9, 1'b1);
    @(negedge clk);
    rc_stall = 4'b0100; br_req = 4'b0001; br_add = {15'd0, 5'd10};
    for (int s = 0; s < 3; s++) begin
      #1 exec_chk("xstall", 5'd7, 1'b0);
      @(negedge clk);
    end
    rc_stall = 4'b0000;
    #1 exec_chk("x7", 5'd7, 1'b1);
    @(negedge clk);
    br_req = 4'b0001; br_add = {15'd0, 5'd20}; exec_end = 4'b1000;
    #1 exec_chk("x10", 5'd10, 1'b1);
    @(negedge clk);
    br_req = 4'b0000; exec_end = 4'b0000;
    #1;
    chk("dn_done", 32'(done), 32'd1);
    chk("dn_re", 32'(conf_re), 32'd0);
    chk("dn_en", 32'(pc_en), 32'd0);
    chk("dn_busy", 32'(busy), 32'd1);
`ifdef CGRA_SEQ_PERF_CNT_EN
    chk("dn_exec_cyc", exec_cyc, 32'd9);
    chk("dn_stall_cyc", stall_cyc, 32'd3);
`else
    chk("dn_exec_cyc", exec_cyc, 32'd0);
    chk("dn_stall_cyc", stall_cyc, 32'd0);
`endif
    @(negedge clk);
    #1;
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
`ifdef CGRA_SEQ_PERF_CNT_EN
    chk("idle_exec_hold", exec_cyc, 32'd9);
`else
    chk("idle_exec_hold", exec_cyc, 32'd0);
`endif

    // PC wrap 31 -> 0, then reset in the middle of EXEC.
    @(negedge clk);
    start = 1'b1; start_pc = 5'd30;
    @(negedge clk);
    start = 1'b0;
    #1 exec_chk("w30", 5'd30, 1'b1);
    @(negedge clk);
    #1 exec_chk("w31", 5'd31, 1'b1);
    @(negedge clk);
    #1 exec_chk("w0", 5'd0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ra_busy", 32'(busy), 32'd0);
    chk("ra_done", 32'(done), 32'd0);
    chk("ra_pc", 32'(gpc), 32'd0);
    chk("ra_en", 32'(pc_en), 32'd0);
    chk("ra_re", 32'(conf_re), 32'd0);
    chk("ra_exec", exec_cyc, 32'd0);

    // load_i and start_i together: the load is taken and the start is dropped.
    @(negedge clk);
    load = 1'b1; start = 1'b1; load_len = 6'd1; start_pc = 5'd5;
    @(negedge clk);
    load = 1'b0; start = 1'b0;
    #1;
    chk("col_rdy", 32'(cfg_ready), 32'd1);
    chk("col_re", 32'(conf_re), 32'd0);
    chk("col_en", 32'(pc_en), 32'd0);
    run_load("col", 4, 1'b0);

    // A load length of 0 loads all 32 addresses.
    @(negedge clk);
    load = 1'b1; load_len = 6'd0;
    @(negedge clk);
    load = 1'b0;
    run_load("full", 128, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
